// File: rtl/psm_phase_decoder.sv
// PSM gate decoder: recovers period, per-leg offsets, folded SPS and leg-0 deadtime
// from the eight gate signals, publishing one measurement set per leg-0 period.
//
// state  | meaning
// S_IDLE | waiting for a leg-0 top rising edge; nothing captured
// S_RUN  | counting since the last leg-0 edge, capturing edges, publishing
module psm_phase_decoder #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   iPSM,
  output logic [W-1:0] oPERIOD,
  output logic [W-1:0] oOFS1,
  output logic [W-1:0] oOFS2,
  output logic [W-1:0] oOFS3,
  output logic [W-1:0] oSPS,
  output logic         oSPS_SIGN,
  output logic [W-1:0] oDEADTIME,
  output logic [3:0]   oMISS,
  output logic         oVALID,
  output logic         oLOCK,
  output logic         oTIMEOUT
);

  localparam int           NS  = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [7:0] sync_q [NS];
  logic [7:0] dly_q;
  logic [7:0] synced;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       unused_edges;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NS; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= iPSM;
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[NS-1];
    end
  end

  assign synced = sync_q[NS-1];
  assign rise   = synced & ~dly_q;
  assign fall   = ~synced & dly_q;
  // Bottom gates of legs 1..3 and all falling edges but leg-0 top are not measured.
  assign unused_edges = ^{rise[7], rise[5], rise[3], fall[7:1]};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0]   flag_q, flag_d;
  logic         armed_q, armed_d;
  logic [W-1:0] fall_cnt_q, fall_cnt_d;
  logic [W-1:0] ofs_q [3];
  logic [W-1:0] ofs_d [3];
  logic [W-1:0] dt_q, dt_d;

  logic [W-1:0] snap_per_q, snap_per_d;
  logic [W-1:0] snap_ofs_q [3];
  logic [W-1:0] snap_ofs_d [3];
  logic [W-1:0] snap_dt_q, snap_dt_d;
  logic [3:0]   snap_flag_q, snap_flag_d;
  logic         pend_q, pend_d;

  logic [W-1:0] period_q, period_d;
  logic [W-1:0] ofso_q [3];
  logic [W-1:0] ofso_d [3];
  logic [W-1:0] sps_q, sps_d;
  logic         sign_q, sign_d;
  logic [W-1:0] dto_q, dto_d;
  logic [3:0]   miss_q, miss_d;
  logic         valid_q, valid_d;
  logic         lock_q, lock_d;

  logic [W-1:0] cur;
  logic [3:0]   fl;
  logic         arm;
  logic [W-1:0] fc;
  logic         timeout_c;
  logic [W-1:0] half;
  logic [W-1:0] ofs2_pub;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    armed_d     = armed_q;
    fall_cnt_d  = fall_cnt_q;
    ofs_d       = ofs_q;
    dt_d        = dt_q;
    snap_per_d  = snap_per_q;
    snap_ofs_d  = snap_ofs_q;
    snap_dt_d   = snap_dt_q;
    snap_flag_d = snap_flag_q;
    pend_d      = 1'b0;
    cur         = cnt_q;
    fl          = flag_q;
    arm         = armed_q;
    fc          = fall_cnt_q;
    timeout_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise[0]) begin
          state_d = S_RUN;
          cnt_d   = ONE;
          flag_d  = '0;
          armed_d = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + ONE;
        if (rise[0]) begin
          snap_per_d  = cnt_q;
          snap_ofs_d  = ofs_q;
          snap_dt_d   = dt_q;
          snap_flag_d = flag_q;
          pend_d      = 1'b1;
          cnt_d       = ONE;
          // Edges coincident with the leg-0 edge belong to the new period at offset 0.
          cur = '0;
          fl  = '0;
          arm = 1'b0;
        end else if (cnt_q == '1) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end

        if (!timeout_c) begin
          for (int k = 1; k < 4; k++) begin
            if (rise[2*k] && !fl[k]) begin
              ofs_d[k-1] = cur;
              fl[k]      = 1'b1;
            end
          end
          if (fall[0] && !fl[0]) begin
            fc  = cur;
            arm = 1'b1;
          end
          if (rise[1] && arm) begin
            dt_d  = cur - fc;
            fl[0] = 1'b1;
            arm   = 1'b0;
          end
          flag_d     = fl;
          armed_d    = arm;
          fall_cnt_d = fc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    half     = snap_per_q >> 1;
    ofs2_pub = snap_flag_q[2] ? snap_ofs_q[1] : '0;
    period_d = period_q;
    ofso_d   = ofso_q;
    sps_d    = sps_q;
    sign_d   = sign_q;
    dto_d    = dto_q;
    miss_d   = miss_q;
    lock_d   = lock_q;
    valid_d  = 1'b0;

    if (pend_q) begin
      period_d = snap_per_q;
      for (int k = 0; k < 3; k++) ofso_d[k] = snap_flag_q[k+1] ? snap_ofs_q[k] : '0;
      dto_d   = snap_flag_q[0] ? snap_dt_q : '0;
      miss_d  = ~snap_flag_q;
      valid_d = 1'b1;
      lock_d  = 1'b1;
      // Fold the bridge-2 offset into a shift of at most half a period.
      if (!snap_flag_q[2]) begin
        sps_d  = '0;
        sign_d = 1'b0;
      end else if (ofs2_pub <= half) begin
        sps_d  = ofs2_pub;
        sign_d = 1'b1;
      end else begin
        sps_d  = snap_per_q - ofs2_pub;
        sign_d = 1'b0;
      end
    end else if (timeout_c) begin
      period_d = '0;
      for (int k = 0; k < 3; k++) ofso_d[k] = '0;
      sps_d  = '0;
      sign_d = 1'b0;
      dto_d  = '0;
      miss_d = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      flag_q      <= '0;
      armed_q     <= 1'b0;
      fall_cnt_q  <= '0;
      dt_q        <= '0;
      snap_per_q  <= '0;
      snap_dt_q   <= '0;
      snap_flag_q <= '0;
      pend_q      <= 1'b0;
      period_q    <= '0;
      sps_q       <= '0;
      sign_q      <= 1'b0;
      dto_q       <= '0;
      miss_q      <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        ofs_q[k]      <= '0;
        snap_ofs_q[k] <= '0;
        ofso_q[k]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      armed_q     <= armed_d;
      fall_cnt_q  <= fall_cnt_d;
      dt_q        <= dt_d;
      snap_per_q  <= snap_per_d;
      snap_dt_q   <= snap_dt_d;
      snap_flag_q <= snap_flag_d;
      pend_q      <= pend_d;
      period_q    <= period_d;
      sps_q       <= sps_d;
      sign_q      <= sign_d;
      dto_q       <= dto_d;
      miss_q      <= miss_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      for (int k = 0; k < 3; k++) begin
        ofs_q[k]      <= ofs_d[k];
        snap_ofs_q[k] <= snap_ofs_d[k];
        ofso_q[k]     <= ofso_d[k];
      end
    end
  end

  assign oPERIOD   = period_q;
  assign oOFS1     = ofso_q[0];
  assign oOFS2     = ofso_q[1];
  assign oOFS3     = ofso_q[2];
  assign oSPS      = sps_q;
  assign oSPS_SIGN = sign_q;
  assign oDEADTIME = dto_q;
  assign oMISS     = miss_q;
  assign oVALID    = valid_q;
  assign oLOCK     = lock_q;
  assign oTIMEOUT  = timeout_c & ~RST;

endmodule
